// File: rtl/dram_resp_if.sv
// Request/response bundle between a requester (master) and dram_resp (slave).
// dram_rerr exists only when DRAM_RANGE_CHECK_EN is defined.
interface dram_resp_if;
  logic        dram_req;
  logic        dram_ready;
  logic        dram_write;
  logic [31:0] dram_addr;
  logic [31:0] dram_wdata;
  logic [3:0]  dram_wstrb;
  logic        dram_rready;
  logic        dram_flush;
  logic        dram_rvalid;
  logic [31:0] dram_rdata;
`ifdef DRAM_RANGE_CHECK_EN
  logic        dram_rerr;
`endif

  modport master (
    output dram_req, dram_write, dram_addr, dram_wdata, dram_wstrb, dram_rready, dram_flush,
    input  dram_ready, dram_rvalid, dram_rdata
`ifdef DRAM_RANGE_CHECK_EN
    , input dram_rerr
`endif
  );

  modport slave (
    input  dram_req, dram_write, dram_addr, dram_wdata, dram_wstrb, dram_rready, dram_flush,
    output dram_ready, dram_rvalid, dram_rdata
`ifdef DRAM_RANGE_CHECK_EN
    , output dram_rerr
`endif
  );
endinterface

// File: rtl/dram_resp.sv
// Word-addressed DRAM model with strobed writes, READ_LAT-cycle read responses and flush.
// Define DRAM_RANGE_CHECK_EN to flag out-of-range accesses on dram_rerr instead of wrapping.
module dram_resp #(
  parameter int unsigned DEPTH_AW = 12,
  parameter int unsigned READ_LAT = 1
) (
  input logic        clk,
  input logic        rst_b,
  dram_resp_if.slave bus
);

  localparam int unsigned Words   = 1 << DEPTH_AW;
  localparam logic [1:0]  LoadCnt = 2'(READ_LAT - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e              r_state, w_state_d;
  logic [1:0]          r_cnt, w_cnt_d;
  logic [DEPTH_AW-1:0] r_idx, w_idx, w_cap_idx;
  logic                r_oob, w_oob, w_cap_oob;
  logic [31:0]         r_rdata;
  logic                r_rerr;
  logic                w_ready, w_accept, w_wr_en, w_rd_accept, w_capture;
  logic                w_unused;
  logic [31:0]         r_mem [Words];

  assign w_idx = bus.dram_addr[DEPTH_AW+1:2];

`ifdef DRAM_RANGE_CHECK_EN
  assign w_oob         = |bus.dram_addr[31:DEPTH_AW+2];
  assign w_unused      = ^bus.dram_addr[1:0];
  assign bus.dram_rerr = r_rerr;
`else
  assign w_oob    = 1'b0;
  assign w_unused = ^{bus.dram_addr[31:DEPTH_AW+2], bus.dram_addr[1:0], r_rerr};
`endif

  always_comb begin
    w_ready     = ~bus.dram_flush &
                  ((r_state == StIdle) | ((r_state == StResp) & bus.dram_rready));
    w_accept    = bus.dram_req & w_ready;
    w_wr_en     = w_accept & bus.dram_write & ~w_oob;
    w_rd_accept = w_accept & ~bus.dram_write;
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_capture   = 1'b0;
    w_cap_idx   = w_idx;
    w_cap_oob   = w_oob;

    unique case (r_state)
      StIdle: begin
        if (w_rd_accept) begin
          w_state_d = (READ_LAT == 1) ? StResp : StWait;
          w_cnt_d   = LoadCnt;
          w_capture = (READ_LAT == 1);
        end
      end
      StWait: begin
        if (bus.dram_flush) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (r_cnt <= 2'd1) begin
          w_state_d = StResp;
          w_cnt_d   = '0;
          w_capture = 1'b1;
          w_cap_idx = r_idx;
          w_cap_oob = r_oob;
        end else begin
          w_cnt_d = r_cnt - 2'd1;
        end
      end
      StResp: begin
        if (bus.dram_flush) begin
          w_state_d = StIdle;
          w_cnt_d   = '0;
        end else if (bus.dram_rready) begin
          // Consuming the response and accepting the next read share one edge
          w_state_d = StIdle;
          if (w_rd_accept) begin
            w_state_d = (READ_LAT == 1) ? StResp : StWait;
            w_cnt_d   = LoadCnt;
            w_capture = (READ_LAT == 1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_oob   <= 1'b0;
      r_rdata <= '0;
      r_rerr  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      if (w_rd_accept) begin
        r_idx <= w_idx;
        r_oob <= w_oob;
      end
      if (w_capture) begin
        r_rdata <= w_cap_oob ? 32'h0 : r_mem[w_cap_idx];
        r_rerr  <= w_cap_oob;
      end
    end
  end

  // Array is not reset; contents survive or not at the integrator's discretion
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.dram_wstrb[b]) r_mem[w_idx][8*b +: 8] <= bus.dram_wdata[8*b +: 8];
      end
    end
  end

  assign bus.dram_ready  = w_ready;
  assign bus.dram_rvalid = (r_state == StResp);
  assign bus.dram_rdata  = r_rdata;

endmodule

// File: tb/tb_dram_resp.sv
// Bench for dram_resp: three instances (READ_LAT 1, 3, 4) share one stimulus set, and a
// scoreboard queue of expected responses is checked whenever a response is consumed.
module tb_dram_resp;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  logic        t_req, t_write, t_rready, t_flush;
  logic [31:0] t_addr, t_wdata;
  logic [3:0]  t_wstrb;
  int          sel;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [32:0] sb_q [$];
  logic [32:0] sb_exp;

  dram_resp_if b1 ();
  dram_resp_if b3 ();
  dram_resp_if b4 ();

  assign b1.dram_req    = t_req & (sel == 0);
  assign b1.dram_write  = t_write;
  assign b1.dram_addr   = t_addr;
  assign b1.dram_wdata  = t_wdata;
  assign b1.dram_wstrb  = t_wstrb;
  assign b1.dram_rready = t_rready;
  assign b1.dram_flush  = t_flush;
  assign b3.dram_req    = t_req & (sel == 1);
  assign b3.dram_write  = t_write;
  assign b3.dram_addr   = t_addr;
  assign b3.dram_wdata  = t_wdata;
  assign b3.dram_wstrb  = t_wstrb;
  assign b3.dram_rready = t_rready;
  assign b3.dram_flush  = t_flush;
  assign b4.dram_req    = t_req & (sel == 2);
  assign b4.dram_write  = t_write;
  assign b4.dram_addr   = t_addr;
  assign b4.dram_wdata  = t_wdata;
  assign b4.dram_wstrb  = t_wstrb;
  assign b4.dram_rready = t_rready;
  assign b4.dram_flush  = t_flush;

  dram_resp #(.DEPTH_AW(12), .READ_LAT(1)) u_l1 (.clk(clk), .rst_b(rst_b), .bus(b1));
  dram_resp #(.DEPTH_AW(12), .READ_LAT(3)) u_l3 (.clk(clk), .rst_b(rst_b), .bus(b3));
  dram_resp #(.DEPTH_AW(12), .READ_LAT(4)) u_l4 (.clk(clk), .rst_b(rst_b), .bus(b4));

  logic        m_ready, m_rvalid, m_rerr;
  logic [31:0] m_rdata;

  always_comb begin
    case (sel)
      0:       begin m_ready = b1.dram_ready; m_rvalid = b1.dram_rvalid; m_rdata = b1.dram_rdata; end
      1:       begin m_ready = b3.dram_ready; m_rvalid = b3.dram_rvalid; m_rdata = b3.dram_rdata; end
      default: begin m_ready = b4.dram_ready; m_rvalid = b4.dram_rvalid; m_rdata = b4.dram_rdata; end
    endcase
`ifdef DRAM_RANGE_CHECK_EN
    case (sel)
      0:       m_rerr = b1.dram_rerr;
      1:       m_rerr = b3.dram_rerr;
      default: m_rerr = b4.dram_rerr;
    endcase
`else
    m_rerr = 1'b0;
`endif
  end

  // Scoreboard: one expected entry per response handed over (rvalid & rready, no flush)
  always @(negedge clk) begin
    if (rst_b && m_rvalid && t_rready && !t_flush) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rvalid=1 rdata=%h, no response expected", m_rdata);
      end else begin
        sb_exp = sb_q.pop_front();
        if (m_rdata !== sb_exp[31:0] || m_rerr !== sb_exp[32]) begin
          n_fail++;
          $display("FAIL sb_rdata: got rdata=%h rerr=%b want rdata=%h rerr=%b",
                   m_rdata, m_rerr, sb_exp[31:0], sb_exp[32]);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold a request until accepted; returns just after the accept edge with req dropped
  task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    int w;
    t_req = 1'b1; t_write = wr; t_addr = a; t_wdata = d; t_wstrb = s;
    w = 0;
    @(negedge clk);
    while (m_ready !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (m_ready !== 1'b1) begin
      n_checks++; n_fail++;
      $display("FAIL accept_timeout: addr=%h ready=%b want 1", a, m_ready);
    end
    @(posedge clk); #1;
    t_req = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [32:0] exp);
    sb_q.push_back(exp);
    issue(1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic drain();
    int w = 0;
    while (sb_q.size() != 0 && w < 30) begin
      tick(1);
      w++;
    end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d responses outstanding, want 0", sb_q.size());
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({b1.dram_rvalid, b3.dram_rvalid, b4.dram_rvalid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_rvalid: got %b want 000",
                         {b1.dram_rvalid, b3.dram_rvalid, b4.dram_rvalid});
    end
    n_checks++;
    if (b1.dram_rdata !== 32'h0 || b3.dram_rdata !== 32'h0 || b4.dram_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h/%h/%h want 0",
                         b1.dram_rdata, b3.dram_rdata, b4.dram_rdata);
    end
    n_checks++;
    if ({b1.dram_ready, b3.dram_ready, b4.dram_ready} !== 3'b111) begin
      n_fail++; $display("FAIL reset_ready: got %b want 111",
                         {b1.dram_ready, b3.dram_ready, b4.dram_ready});
    end
    rst_b = 1'b1;
    tick(1);
  endtask

  task automatic test_basic();
    sel = 0;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    do_read(32'h10, {1'b0, 32'hDEADBEEF});
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL lat1_rvalid: got %b want 1 one cycle after accept", m_rvalid);
    end
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL lat1_release: rvalid=%b want 0 after consume", m_rvalid);
    end
    tick(1);
  endtask

  task automatic test_partial();
    sel = 0;
    issue(1'b1, 32'h20, 32'h11223344, 4'hF);
    issue(1'b1, 32'h20, 32'h000000AA, 4'h1);
    do_read(32'h20, {1'b0, 32'h112233AA});
    issue(1'b1, 32'h24, 32'hFFFFFFFF, 4'hF);
    issue(1'b1, 32'h24, 32'h12345678, 4'hA);
    do_read(32'h24, {1'b0, 32'h12FF56FF});
    issue(1'b1, 32'h28, 32'h5A5A5A5A, 4'hF);
    do_read(32'h28, {1'b0, 32'h5A5A5A5A});
    drain();
  endtask

  task automatic test_wrap();
    sel = 0;
    issue(1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 32'h8, 32'h11111111, 4'hF);
    issue(1'b1, 32'h4008, 32'h0000BEEF, 4'hF);
`ifdef DRAM_RANGE_CHECK_EN
    do_read(32'h4000, {1'b1, 32'h0});
    do_read(32'h8, {1'b0, 32'h11111111});
`else
    do_read(32'h4000, {1'b0, 32'hCAFEF00D});
    do_read(32'h8, {1'b0, 32'h0000BEEF});
`endif
    do_read(32'h3, {1'b0, 32'hCAFEF00D});
    drain();
  endtask

  task automatic test_back_to_back();
    sel = 0;
    issue(1'b1, 32'h0, 32'hA0A0A0A0, 4'hF);
    issue(1'b1, 32'h4, 32'hB1B1B1B1, 4'hF);
    sb_q.push_back({1'b0, 32'hA0A0A0A0});
    sb_q.push_back({1'b0, 32'hB1B1B1B1});
    t_req = 1'b1; t_write = 1'b0; t_addr = 32'h0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b want 1", m_ready); end
    @(posedge clk); #1;
    t_addr = 32'h4;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b1 || m_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_first: rvalid=%b ready=%b want 1/1", m_rvalid, m_ready);
    end
    @(posedge clk); #1;
    t_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL b2b_second: rvalid=%b want 1 (no bubble)", m_rvalid);
    end
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: rvalid=%b want 0", m_rvalid); end
    drain();
  endtask

  task automatic test_latency3();
    int lat;
    sel = 1;
    issue(1'b1, 32'h30, 32'h0BADF00D, 4'hF);
    t_rready = 1'b0;
    do_read(32'h30, {1'b0, 32'h0BADF00D});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_rvalid !== 1'b1 && lat < 10);
    n_checks++;
    if (lat != 3) begin n_fail++; $display("FAIL lat3_latency: got %0d want 3", lat); end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      n_checks++;
      if (m_rvalid !== 1'b1 || m_rdata !== 32'h0BADF00D || m_ready !== 1'b0) begin
        n_fail++; $display("FAIL lat3_hold: cycle %0d rvalid=%b rdata=%h ready=%b want 1/0badf00d/0",
                           k, m_rvalid, m_rdata, m_ready);
      end
    end
    @(posedge clk); #1;
    t_rready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b1) begin n_fail++; $display("FAIL lat3_consume: rvalid=%b want 1", m_rvalid); end
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b0) begin n_fail++; $display("FAIL lat3_drop: rvalid=%b want 0", m_rvalid); end
    drain();
  endtask

  task automatic test_flush_wait();
    int lat;
    int seen;
    sel = 2;
    t_flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0) begin n_fail++; $display("FAIL flush_idle_ready: got %b want 0", m_ready); end
    tick(1);
    t_flush = 1'b0;
    issue(1'b1, 32'h40, 32'h44444444, 4'hF);
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    tick(1);
    t_flush = 1'b1;
    tick(1);
    t_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b1 || m_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL flush_wait_idle: ready=%b rvalid=%b want 1/0", m_ready, m_rvalid);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL flush_wait_resp: %0d rvalid cycles want 0", seen); end
    tick(1);
    do_read(32'h40, {1'b0, 32'h44444444});
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (m_rvalid !== 1'b1 && lat < 10);
    n_checks++;
    if (lat != 4) begin n_fail++; $display("FAIL lat4_latency: got %0d want 4", lat); end
    drain();
  endtask

  task automatic test_flush_resp();
    int seen;
    sel = 0;
    t_rready = 1'b0;
    issue(1'b1, 32'h50, 32'h50505050, 4'hF);
    issue(1'b0, 32'h50, 32'h0, 4'h0);
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b1 || m_rdata !== 32'h50505050) begin
      n_fail++; $display("FAIL fresp_hold: rvalid=%b rdata=%h want 1/50505050", m_rvalid, m_rdata);
    end
    @(posedge clk); #1;
    t_req = 1'b1; t_write = 1'b0; t_addr = 32'h50; t_rready = 1'b1; t_flush = 1'b1;
    @(negedge clk);
    n_checks++;
    if (m_ready !== 1'b0) begin n_fail++; $display("FAIL fresp_ready: got %b want 0", m_ready); end
    @(posedge clk); #1;
    t_req = 1'b0; t_flush = 1'b0;
    @(negedge clk);
    n_checks++;
    if (m_rvalid !== 1'b0 || m_rdata !== 32'h50505050) begin
      n_fail++; $display("FAIL fresp_drop: rvalid=%b rdata=%h want 0/50505050", m_rvalid, m_rdata);
    end
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL fresp_prio: %0d rvalid cycles want 0", seen); end
    tick(1);
  endtask

  task automatic test_reset_midop();
    int seen;
    sel = 0;
    t_rready = 1'b0;
    issue(1'b1, 32'h60, 32'h66666666, 4'hF);
    issue(1'b0, 32'h60, 32'h0, 4'h0);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if (m_rvalid !== 1'b0 || m_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_async_resp: rvalid=%b rdata=%h want 0/0", m_rvalid, m_rdata);
    end
    @(posedge clk); #1;
    rst_b = 1'b1;
    t_rready = 1'b1;
    sel = 2;
    issue(1'b0, 32'h40, 32'h0, 4'h0);
    @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    n_checks++;
    if (m_ready !== 1'b1) begin n_fail++; $display("FAIL rst_async_wait: ready=%b want 1", m_ready); end
    @(posedge clk); #1;
    rst_b = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (m_rvalid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL rst_no_resp: %0d rvalid cycles want 0", seen); end
    tick(1);
  endtask

  initial begin
    rst_b = 1'b0;
    t_req = 1'b0; t_write = 1'b0; t_addr = '0; t_wdata = '0; t_wstrb = '0;
    t_rready = 1'b1; t_flush = 1'b0;
    sel = 0;
    test_reset();
    test_basic();
    test_partial();
    test_wrap();
    test_back_to_back();
    test_latency3();
    test_flush_wait();
    test_flush_resp();
    test_reset_midop();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++; $display("FAIL sb_leftover: %0d expected responses never seen, want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dram_resp.md
DRAM_RESP -- requirements
Module: dram_resp

Interface
REQ-001 SHALL have parameter DEPTH_AW, default 12: word-address width; array holds 2^DEPTH_AW 32-bit words.
REQ-002 SHALL have parameter READ_LAT, default 1, legal range 1..4: cycles from read-accept edge to dram_rvalid high.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_b, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port dram_req, input, 1: request valid.
REQ-006 SHALL have port dram_ready, output, 1: request accepted when dram_req & dram_ready.
REQ-007 SHALL have port dram_write, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port dram_addr, input, 32: byte address; bits [1:0] ignored.
REQ-009 SHALL have port dram_wdata, input, 32: write data.
REQ-010 SHALL have port dram_wstrb, input, 4: byte-lane enables; bit n covers wdata[8n+7:8n].
REQ-011 SHALL have port dram_rready, input, 1: requester consumes the response.
REQ-012 SHALL have port dram_flush, input, 1: discards any pending or held read.
REQ-013 SHALL have port dram_rvalid, output, 1: read response valid.
REQ-014 SHALL have port dram_rdata, output, 32: full read word; the requester selects byte/half and sign-extends.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive dram_ready = ~dram_flush & (IDLE | (RESP & dram_rready)).
REQ-017 SHALL write an accepted request at the accept edge, updating only strobed lanes; no response; state unchanged.
REQ-018 SHALL, on an accepted read, move to RESP if READ_LAT==1, else to WAIT with counter loaded to READ_LAT-1.
REQ-019 SHALL, in WAIT, decrement the counter each cycle and enter RESP when it reaches 0.
REQ-020 SHALL capture read data on RESP entry, so dram_rvalid rises exactly READ_LAT cycles after the accept edge.
REQ-021 SHALL, in RESP, hold dram_rvalid=1 and dram_rdata stable until dram_rready=1.
REQ-022 SHALL, in RESP with dram_rready=1, go to IDLE, or straight to the new request's path if dram_req is also accepted that cycle (back-to-back, no bubble).
REQ-023 SHALL, when dram_flush=1 in WAIT or RESP, go to IDLE next cycle, drop the read, and drive dram_rvalid=0 from that next cycle.
REQ-024 SHALL give dram_flush priority over dram_rready and dram_req in the same cycle.
REQ-025 SHALL keep dram_rdata at its last captured value while dram_rvalid=0.
REQ-026 SHALL return the newly written value when a write at the accept edge is followed by a read of the same word (write-first).
REQ-027 SHALL form the word index from dram_addr[DEPTH_AW+1:2] and, without the range check, ignore higher bits (wrap-around).

Reset
REQ-028 SHALL, while rst_b=0, asynchronously force state IDLE, counter 0, dram_rvalid 0 and dram_rdata 0.
REQ-029 SHALL drop any in-flight read on reset assert mid-operation, with no response after release.
REQ-030 SHALL leave array contents undefined after reset.

Configuration
REQ-031 SHALL, with macro DRAM_RANGE_CHECK_EN defined, add output dram_rerr (1 bit, reset 0) that is valid with dram_rvalid.
REQ-032 SHALL, with DRAM_RANGE_CHECK_EN defined and any dram_addr[31:DEPTH_AW+2] bit set, drop writes, and answer reads normally but with dram_rdata=0 and dram_rerr=1.
REQ-033 SHALL, without DRAM_RANGE_CHECK_EN, omit dram_rerr and wrap addresses per REQ-027.

Verification
REQ-034 SHALL test READ_LAT=1: write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> rvalid one cycle after accept, rdata=0xDEADBEEF.
REQ-035 SHALL test partial write: 0x11223344 at 0x20, then wdata 0x000000AA with wstrb=0x1, then read -> 0x112233AA.
REQ-036 SHALL test READ_LAT=3 with rready=0 for 5 cycles -> rvalid rises 3 cycles after accept, rdata stable for 5 cycles, deasserts the cycle after rready=1.
REQ-037 SHALL test back-to-back reads of 0x0 and 0x4 with rready=1 and READ_LAT=1 -> two consecutive rvalid cycles with no bubble.
REQ-038 SHALL test flush in WAIT (READ_LAT=4, flush 2 cycles after accept) -> no rvalid for that read, dram_ready=1 the next cycle.
REQ-039 SHALL test range check (DRAM_RANGE_CHECK_EN, DEPTH_AW=12): read 0x4000 -> rvalid, rdata=0, dram_rerr=1; without the macro, read 0x4000 -> same data as 0x0.
